qupls_regrd_arb: RTL and testbench
==================================

Name: qupls_regrd_arb

Overview:
- Arbitrates source-register read requests onto a smaller set of register-file read ports.
- Requesters are the Ra/Rb/Rc operand fields produced by the decode stage for up to a group of instructions.
- Shares ports between requesters that name the same register, short-circuits r0, and rotates priority round-robin so no requester starves.
- Routes synchronous register-file read data back to each granted requester one cycle after grant.

Parameters:
- NREQ, 8, number of operand requesters.
- NPORT, 4, number of register-file read ports.
- AW, 7, register-number width ({regx, 6-bit field}).
- DW, 64, register data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  requester i wants a read; held until req_ready[i]
- req_reg  in  NREQ*AW  register number, slice i*AW +: AW
- req_ready  out  NREQ  combinational grant for this cycle
- rf_en  out  NPORT  read-port enable (combinational)
- rf_ra  out  NPORT*AW  read-port address (combinational)
- rf_rd  in  NPORT*DW  register-file data, valid the cycle after rf_en
- resp_valid  out  NREQ  registered: data for requester i present
- resp_data  out  NREQ*DW  registered per-requester data
- busy  out  1  any req_valid denied this cycle

Behaviour:
- The single clock domain is clk. Reset rst is synchronous and active-high.
- Reset values:
  - rr_ptr=0; resp_valid=0; resp_data=0; per-requester port-select and zero flags = 0.
  - While rst=1: req_ready=0, rf_en=0, rf_ra=0, busy=0.
- Allocation is combinational each cycle. Scan requesters in circular order starting at rr_ptr. For each requester with req_valid=1:
  - req_reg==0: grant; mark zero; no port consumed.
  - req_reg equals the address of a port already allocated this cycle: grant; share that port.
  - Otherwise, if an unallocated port remains: allocate the lowest free port index; rf_ra = req_reg, rf_en=1; grant.
  - Otherwise: deny (req_ready=0).
- Unused ports: rf_en=0, rf_ra=0.
- Priority update at the clock edge:
  - If any requester was denied, rr_ptr = first denied index in scan order.
  - Otherwise rr_ptr is unchanged.
  - This guarantees the oldest-denied requester gets a port the next cycle (NPORT≥1), so worst-case wait is ceil(NREQ/NPORT)-1 cycles.
- Response pipeline, latency 1:
  - At the grant edge, register sel_q[i] = port index and zero_q[i] = zero flag.
  - Next cycle: resp_valid[i]=1; resp_data[i] = zero_q[i] ? 0 : rf_rd[sel_q[i]].
  - resp_valid[i] deasserts the following cycle unless re-granted.
  - resp_data holds its last value when resp_valid=0.
- A requester may drop req_valid before grant. No state is retained; the request is simply not served.
- Back-to-back grants to the same requester are legal; the response is produced each cycle.
- rr_ptr wraps NREQ-1 → 0 via the modulo scan.
- Reset mid-operation: any grant made in the cycle before rst asserts produces no response. resp_valid is forced 0 in the cycle after the reset edge.
- Requests with req_valid=0 are ignored even if req_reg matches a port.

Test Plan:
- Reset, then req_valid=8'h0F with regs 5,6,7,8 → req_ready=8'h0F; rf_ra = 5,6,7,8 on ports 0-3; next cycle resp_valid=8'h0F, resp_data[i] = rf_rd of port i.
- All 8 valid, regs 1..8, rr_ptr=0 → cycle 0 grants req 0-3, busy=1, rr_ptr→4; cycle 1 grants req 4-7, busy=0; each resp_valid pulses exactly once, one cycle after its grant.
- All 8 valid, all req_reg=9 → one port used (rf_en=4'b0001, rf_ra=9); req_ready=8'hFF; all 8 resp_data equal rf_rd port 0.
- req 2 and req 5 with req_reg=0, others idle → req_ready=8'h24, rf_en=0; next cycle resp_valid=8'h24, resp_data=0 even with rf_rd driven to all ones.
- Starvation check: rr_ptr=6, 6 valid requests on distinct regs (req 0-5), with req 6,7 idle → grants 0-3, rr_ptr→4 → next cycle req 4,5 granted; no request waits more than 1 cycle.
- rst asserted the cycle after granting 8'h0F → resp_valid stays 0, rr_ptr=0, req_ready=0 during reset; normal grants resume the first cycle rst=0.

Source files
------------

// File: rtl/qupls_regrd_arb.sv
// Register-file read-port arbiter: maps operand read requests onto
// fewer read ports with address sharing, r0 short-circuit and round-robin.
module qupls_regrd_arb #(
    parameter int NREQ  = 8,
    parameter int NPORT = 4,
    parameter int AW    = 7,
    parameter int DW    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*AW-1:0]    req_reg,
    output logic [NREQ-1:0]       req_ready,
    output logic [NPORT-1:0]      rf_en,
    output logic [NPORT*AW-1:0]   rf_ra,
    input  logic [NPORT*DW-1:0]   rf_rd,
    output logic [NREQ-1:0]       resp_valid,
    output logic [NREQ*DW-1:0]    resp_data,
    output logic                  busy
);

    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int CW = $clog2(NPORT + 1);

    logic [RW-1:0]              rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]            resp_valid_q, resp_valid_d;
    logic [NREQ-1:0]            zero_q, zero_d;
    logic [NREQ-1:0][PW-1:0]    sel_q, sel_d;
    logic [NREQ-1:0][DW-1:0]    hold_q, hold_d;

    logic [NREQ-1:0]            grant;
    logic [NREQ-1:0]            zflag;
    logic [NREQ-1:0]            deny;
    logic [NREQ-1:0][PW-1:0]    gsel;
    logic [NPORT-1:0]           pen;
    logic [NPORT-1:0][AW-1:0]   pra;
    logic [CW-1:0]              nalloc;
    logic                       found_deny;
    logic [RW-1:0]              first_deny;
    logic [RW-1:0]              idx;
    logic [AW-1:0]              rnum;
    logic                       hit;
    logic [PW-1:0]              hit_port;
    logic [NREQ-1:0][DW-1:0]    mux_data;

    // Circular scan from rr_ptr: r0 bypass, port sharing, then fresh ports.
    always_comb begin
        grant      = '0;
        zflag      = '0;
        deny       = '0;
        gsel       = '0;
        pen        = '0;
        pra        = '0;
        nalloc     = '0;
        found_deny = 1'b0;
        first_deny = rr_ptr_q;
        idx        = '0;
        rnum       = '0;
        hit        = 1'b0;
        hit_port   = '0;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                idx  = RW'((int'(rr_ptr_q) + k) % NREQ);
                rnum = req_reg[int'(idx)*AW +: AW];
                hit      = 1'b0;
                hit_port = '0;
                for (int p = 0; p < NPORT; p++) begin
                    if (pen[p] && pra[p] == rnum && !hit) begin
                        hit      = 1'b1;
                        hit_port = PW'(p);
                    end
                end
                if (req_valid[idx]) begin
                    if (rnum == '0) begin
                        grant[idx] = 1'b1;
                        zflag[idx] = 1'b1;
                    end else if (hit) begin
                        grant[idx] = 1'b1;
                        gsel[idx]  = hit_port;
                    end else if (int'(nalloc) < NPORT) begin
                        pen[PW'(nalloc)] = 1'b1;
                        pra[PW'(nalloc)] = rnum;
                        grant[idx]       = 1'b1;
                        gsel[idx]        = PW'(nalloc);
                        nalloc           = nalloc + CW'(1);
                    end else begin
                        deny[idx] = 1'b1;
                        if (!found_deny) begin
                            found_deny = 1'b1;
                            first_deny = idx;
                        end
                    end
                end
            end
        end
    end

    // Steer port data to each requester granted last cycle.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            mux_data[i] = zero_q[i] ? '0
                        : rf_rd[int'(sel_q[i])*DW +: DW];
        end
    end

    // Next-state: oldest denied gets priority, capture grant routing.
    always_comb begin
        rr_ptr_d     = found_deny ? first_deny : rr_ptr_q;
        resp_valid_d = grant;
        zero_d       = zero_q;
        sel_d        = sel_q;
        hold_d       = hold_q;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                zero_d[i] = zflag[i];
                sel_d[i]  = gsel[i];
            end
            if (resp_valid_q[i]) begin
                hold_d[i] = mux_data[i];
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            resp_valid_q <= '0;
            zero_q       <= '0;
            sel_q        <= '0;
            hold_q       <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            zero_q       <= zero_d;
            sel_q        <= sel_d;
            hold_q       <= hold_d;
        end
    end

    // Output drive; responses are suppressed while reset is held.
    always_comb begin
        req_ready  = grant;
        rf_en      = pen;
        rf_ra      = pra;
        busy       = |deny;
        resp_valid = rst ? '0 : resp_valid_q;
        resp_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            resp_data[i*DW +: DW] = resp_valid[i] ? mux_data[i] : hold_q[i];
        end
    end

endmodule

// File: tb/tb_qupls_regrd_arb.sv
// Bench for qupls_regrd_arb: directed vector table plus randomized
// traffic checked against a queue-based allocation model.
module tb_qupls_regrd_arb;

    localparam int NREQ  = 8;
    localparam int NPORT = 4;
    localparam int AW    = 7;
    localparam int DW    = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_reg;
    logic [NREQ-1:0]      req_ready;
    logic [NPORT-1:0]     rf_en;
    logic [NPORT*AW-1:0]  rf_ra;
    logic [NPORT*DW-1:0]  rf_rd;
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ*DW-1:0]   resp_data;
    logic                 busy;

    int n_checks = 0;
    int n_fail   = 0;

    qupls_regrd_arb #(.NREQ(NREQ), .NPORT(NPORT), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_reg(req_reg), .req_ready(req_ready),
        .rf_en(rf_en), .rf_ra(rf_ra), .rf_rd(rf_rd),
        .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model state
    int               m_ptr;
    bit               m_pv [NREQ];
    bit               m_pz [NREQ];
    int               m_pp [NREQ];
    logic [DW-1:0]    m_hold [NREQ];
    int               n_ptr;
    bit               n_g [NREQ];
    bit               n_z [NREQ];
    int               n_p [NREQ];

    logic [NREQ-1:0]      e_ready;
    logic [NPORT-1:0]     e_en;
    logic [NPORT*AW-1:0]  e_ra;
    logic                 e_busy;
    logic [NREQ-1:0]      e_rvalid;
    logic [NREQ*DW-1:0]   e_rdata;

    task automatic check(input string name, input logic [NREQ*DW-1:0] act,
                         input logic [NREQ*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < NREQ; i++) begin
            m_pv[i] = 0; m_pz[i] = 0; m_pp[i] = 0; m_hold[i] = '0;
        end
    endtask

    // Compute expected outputs for the present inputs and model state.
    task automatic model_eval();
        int alloc[$];
        int first;
        int i;
        int r;
        int found;
        e_ready = '0; e_en = '0; e_ra = '0; e_busy = 0; first = -1;
        for (int k = 0; k < NREQ; k++) begin
            n_g[k] = 0; n_z[k] = 0; n_p[k] = 0;
        end
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                i = (m_ptr + k) % NREQ;
                if (!req_valid[i]) continue;
                r = int'(req_reg[i*AW +: AW]);
                found = -1;
                foreach (alloc[p]) if (alloc[p] == r && found < 0) found = p;
                if (r == 0) begin
                    n_g[i] = 1; n_z[i] = 1;
                end else if (found >= 0) begin
                    n_g[i] = 1; n_p[i] = found;
                end else if (alloc.size() < NPORT) begin
                    alloc.push_back(r);
                    n_g[i] = 1; n_p[i] = alloc.size() - 1;
                end else if (first < 0) begin
                    first = i;
                end
            end
        end
        foreach (alloc[p]) begin
            e_en[p] = 1'b1;
            e_ra[p*AW +: AW] = AW'(alloc[p]);
        end
        for (int k = 0; k < NREQ; k++) e_ready[k] = n_g[k];
        e_busy = (first >= 0);
        n_ptr  = (first >= 0) ? first : m_ptr;
        e_rdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            e_rvalid[k] = !rst && m_pv[k];
            if (e_rvalid[k])
                e_rdata[k*DW +: DW] = m_pz[k] ? '0 : rf_rd[m_pp[k]*DW +: DW];
            else
                e_rdata[k*DW +: DW] = m_hold[k];
        end
    endtask

    task automatic model_advance();
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_pv[k]) m_hold[k] = m_pz[k] ? '0 : rf_rd[m_pp[k]*DW +: DW];
                m_pv[k] = n_g[k];
                if (n_g[k]) begin
                    m_pz[k] = n_z[k];
                    m_pp[k] = n_p[k];
                end
            end
            m_ptr = n_ptr;
        end
    endtask

    task automatic drive(input logic r, input logic [NREQ-1:0] v,
                         input logic [NREQ*AW-1:0] rg, input logic ones);
        rst = r;
        req_valid = v;
        req_reg = rg;
        for (int p = 0; p < NPORT; p++)
            rf_rd[p*DW +: DW] = ones ? {DW{1'b1}} : {$urandom, $urandom};
        #3;
        model_eval();
    endtask

    task automatic check_model();
        check("ready", NREQ*DW'(req_ready), NREQ*DW'(e_ready));
        check("rf_en", NREQ*DW'(rf_en), NREQ*DW'(e_en));
        check("rf_ra", NREQ*DW'(rf_ra), NREQ*DW'(e_ra));
        check("busy", NREQ*DW'(busy), NREQ*DW'(e_busy));
        check("resp_valid", NREQ*DW'(resp_valid), NREQ*DW'(e_rvalid));
        check("resp_data", resp_data, e_rdata);
    endtask

    task automatic advance();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic           rst;
        logic [7:0]     valid;
        int             mode;
        logic           ones;
        logic [7:0]     ready;
        logic [3:0]     en;
        logic [27:0]    ra;
        logic           busy;
        logic [7:0]     rvalid;
    } vec_t;

    function automatic logic [27:0] pk(input int a, input int b,
                                       input int c, input int d);
        return {7'(d), 7'(c), 7'(b), 7'(a)};
    endfunction

    function automatic logic [NREQ*AW-1:0] mkregs(input int mode);
        logic [NREQ*AW-1:0] v;
        v = '0;
        for (int i = 0; i < NREQ; i++) begin
            case (mode)
                0: v[i*AW +: AW] = AW'(i + 1);
                1: v[i*AW +: AW] = (i < 4) ? AW'(i + 5) : '0;
                2: v[i*AW +: AW] = AW'(9);
                default: v[i*AW +: AW] = '0;
            endcase
        end
        return v;
    endfunction

    function automatic vec_t mkv(input logic r, input logic [7:0] v,
                                 input int m, input logic o,
                                 input logic [7:0] rd, input logic [3:0] en,
                                 input logic [27:0] ra, input logic b,
                                 input logic [7:0] rv);
        vec_t t;
        t.rst = r; t.valid = v; t.mode = m; t.ones = o;
        t.ready = rd; t.en = en; t.ra = ra; t.busy = b; t.rvalid = rv;
        return t;
    endfunction

    vec_t tbl [18];

    initial begin
        logic [NREQ-1:0]    v;
        logic [NREQ*AW-1:0] rg;
        logic [NREQ-1:0]    pend_deny;
        logic               r;

        tbl[0]  = mkv(1, 8'hFF, 0, 0, 8'h00, 4'h0, pk(0,0,0,0), 0, 8'h00);
        tbl[1]  = mkv(0, 8'h0F, 1, 0, 8'h0F, 4'hF, pk(5,6,7,8), 0, 8'h00);
        tbl[2]  = mkv(0, 8'h00, 0, 0, 8'h00, 4'h0, pk(0,0,0,0), 0, 8'h0F);
        tbl[3]  = mkv(0, 8'hFF, 0, 0, 8'h0F, 4'hF, pk(1,2,3,4), 1, 8'h00);
        tbl[4]  = mkv(0, 8'hF0, 0, 0, 8'hF0, 4'hF, pk(5,6,7,8), 0, 8'h0F);
        tbl[5]  = mkv(0, 8'h00, 0, 0, 8'h00, 4'h0, pk(0,0,0,0), 0, 8'hF0);
        tbl[6]  = mkv(0, 8'hFF, 2, 0, 8'hFF, 4'h1, pk(9,0,0,0), 0, 8'h00);
        tbl[7]  = mkv(0, 8'h00, 0, 0, 8'h00, 4'h0, pk(0,0,0,0), 0, 8'hFF);
        tbl[8]  = mkv(0, 8'h24, 3, 0, 8'h24, 4'h0, pk(0,0,0,0), 0, 8'h00);
        tbl[9]  = mkv(0, 8'h00, 0, 1, 8'h00, 4'h0, pk(0,0,0,0), 0, 8'h24);
        tbl[10] = mkv(0, 8'hF4, 0, 0, 8'hF0, 4'hF, pk(5,6,7,8), 1, 8'h00);
        tbl[11] = mkv(0, 8'h7C, 0, 0, 8'h3C, 4'hF, pk(3,4,5,6), 1, 8'hF0);
        tbl[12] = mkv(0, 8'h3F, 0, 0, 8'h0F, 4'hF, pk(1,2,3,4), 1, 8'h3C);
        tbl[13] = mkv(0, 8'h30, 0, 0, 8'h30, 4'h3, pk(5,6,0,0), 0, 8'h0F);
        tbl[14] = mkv(0, 8'h0F, 0, 0, 8'h0F, 4'hF, pk(1,2,3,4), 0, 8'h30);
        tbl[15] = mkv(1, 8'hFF, 0, 0, 8'h00, 4'h0, pk(0,0,0,0), 0, 8'h00);
        tbl[16] = mkv(0, 8'hFF, 0, 0, 8'h0F, 4'hF, pk(1,2,3,4), 1, 8'h00);
        tbl[17] = mkv(0, 8'hF0, 0, 0, 8'hF0, 4'hF, pk(5,6,7,8), 0, 8'h0F);

        rst = 1'b1;
        req_valid = '0;
        req_reg = '0;
        rf_rd = '0;
        model_reset();
        @(posedge clk);
        #1;

        for (int t = 0; t < 18; t++) begin
            drive(tbl[t].rst, tbl[t].valid, mkregs(tbl[t].mode), tbl[t].ones);
            check_model();
            check($sformatf("v%0d_ready", t), NREQ*DW'(req_ready),
                  NREQ*DW'(tbl[t].ready));
            check($sformatf("v%0d_en", t), NREQ*DW'(rf_en),
                  NREQ*DW'(tbl[t].en));
            check($sformatf("v%0d_ra", t), NREQ*DW'(rf_ra),
                  NREQ*DW'(tbl[t].ra));
            check($sformatf("v%0d_busy", t), NREQ*DW'(busy),
                  NREQ*DW'(tbl[t].busy));
            check($sformatf("v%0d_rvalid", t), NREQ*DW'(resp_valid),
                  NREQ*DW'(tbl[t].rvalid));
            advance();
        end

        // Hand-written: r0 responses read as zero while the RF drives ones.
        drive(0, 8'h81, mkregs(3), 0);
        check("zero_ready", NREQ*DW'(req_ready), NREQ*DW'(8'h81));
        check("zero_en", NREQ*DW'(rf_en), '0);
        advance();
        drive(0, 8'h00, mkregs(3), 1);
        check("zero_rvalid", NREQ*DW'(resp_valid), NREQ*DW'(8'h81));
        check("zero_data0", NREQ*DW'(resp_data[0 +: DW]), '0);
        check("zero_data7", NREQ*DW'(resp_data[7*DW +: DW]), '0);
        check_model();
        advance();

        // Randomized traffic; denied requesters usually keep asking.
        pend_deny = '0;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom % 25) == 0;
            v = NREQ'($urandom);
            if ($urandom % 2 == 1) v = v | pend_deny;
            for (int i = 0; i < NREQ; i++)
                rg[i*AW +: AW] = AW'($urandom_range(0, 5)
                               | (($urandom % 4 == 0) ? 64 : 0));
            drive(r, v, rg, ($urandom % 16) == 0);
            check_model();
            pend_deny = v & ~e_ready;
            if (r) pend_deny = '0;
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
